indirect_mem_seq: RTL and testbench
===================================

Name: indirect_mem_seq

Overview:
- Parametrised MEM-stage data-memory access sequencer. Generalises the fixed single-level LDI/STI counter and stall logic to N levels of pointer indirection and configurable word/byte widths.
- Sits between the EX/MEM pipe register and the data-cache port.
- Issues pointer fetches and then the final load/store, handles byte-lane select and fill, and holds the pipeline with a stall until the access retires.

Parameters:
- WIDTH, 16, data/address word width in bits; multiple of 8, at least 16.
- MAX_INDIR, 2, maximum pointer-indirection levels per request (0 = plain LDR/STR).
- LANES, WIDTH/8, number of byte lanes; derived, never overridden.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  EX/MEM holds a valid memory op (cs.dcache_enable & valid).
- req_write  in  1  1 = store, 0 = load.
- req_byte  in  1  byte-sized final access (LDB/STB).
- req_indir  in  clog2(MAX_INDIR+1)  indirection levels for this request.
- req_addr  in  WIDTH  effective address from EX.
- req_wdata  in  WIDTH  store data.
- flush  in  1  branch/trap squash from the MEM stage.
- d_mem_resp  in  1  cache response for the current strobe.
- d_mem_rdata  in  WIDTH  cache read data.
- d_mem_address  out  WIDTH  cache address.
- d_mem_read  out  1  cache read strobe.
- d_mem_write  out  1  cache write strobe.
- d_mem_wdata  out  WIDTH  cache write data.
- d_mem_byte_enable  out  LANES  write byte enables.
- stall  out  1  freeze IF/ID/EX/MEM pipe registers.
- done  out  1  one-cycle pulse: access retired, MEM/WB may load.
- rdata  out  WIDTH  load result; valid only while done=1.

Behaviour:
- Reset: while rst_n=0 at a clock edge, state goes to IDLE and the level counter and pointer register clear to 0. Outputs while in IDLE with req_valid=0: d_mem_read/write=0, d_mem_address=0, d_mem_wdata=0, d_mem_byte_enable=0, stall=0, done=0, rdata=0.
- States: IDLE, PTR, TURN, FINAL.
- IDLE, req_valid=1, flush=0:
  - stall=1 combinationally.
  - Latch addr, wdata, byte, write; load the level counter with req_indir.
  - Next state is PTR if req_indir>0, otherwise FINAL.
  - Cycle 0 is accept; strobes first assert in cycle 1.
- IDLE, req_valid=1, flush=1: request ignored, stall=0.
- PTR:
  - d_mem_read=1; d_mem_address = pointer with lane bits forced to 0 (word aligned); byte_enable=0.
  - On resp: pointer <= d_mem_rdata, counter decrements, next state TURN.
- TURN: one cycle with both strobes low, mandatory between accesses. Next state is PTR if counter>0, otherwise FINAL.
- FINAL, load (d_mem_read=1):
  - Word access: rdata = d_mem_rdata.
  - Byte access: rdata = zero-extended lane selected by address[clog2(LANES)-1:0].
- FINAL, store (d_mem_write=1):
  - Word access: wdata = stored word, byte_enable all ones.
  - Byte access: low byte replicated into all lanes; byte_enable is one-hot on the addressed lane.
- FINAL on resp: done=1 and stall=0 in that same cycle; next state IDLE.
- Address for FINAL: the latched pointer if indirection was used, otherwise the latched req_addr.
- Latency: direct access is 2 + resp wait cycles. Each indirection level adds 2 + its resp wait.
- Strobes and address stay stable until resp; no retraction mid-transaction.
- Flush during PTR/TURN/FINAL:
  - Record a sticky abort bit.
  - The in-flight strobe completes normally, because a cache transaction is never abandoned.
  - After that resp, return to IDLE without further accesses. done stays 0 and stall drops in that resp cycle.
  - A flush in TURN returns to IDLE immediately.
- Back-to-back requests: a new request is accepted in IDLE the cycle after done.
- req_* inputs are ignored outside IDLE.
- Reset mid-operation overrides everything: IDLE next cycle, strobes low, no done.
- req_indir > MAX_INDIR is saturated to MAX_INDIR.
- Pointer arithmetic is none; pointer values are used verbatim modulo WIDTH.

Decomposition:
- lc3b_types gets:
  - the state enum lc3b_mseq_state (IDLE, PTR, TURN, FINAL);
  - the LANES-derived helper constant.
- One natural sub-module, byte_lane_unit: combinational LDB lane select/zero-extend and STB fill/byte-enable generation, parametrised by WIDTH.
- The FSM and counter stay in indirect_mem_seq.

Test Plan:
- Direct LDR, req_addr=0x1000, req_indir=0, resp after 1 wait cycle, rdata 0xBEEF.
  - Expected: read strobe in cycles 1-2 at 0x1000, done in cycle 2 with rdata=0xBEEF.
  - stall=1 in cycles 0-1 and 0 in cycle 2.
- LDI, req_indir=1, mem[0x2001→0x2000]=0x3000, mem[0x3000]=0x1234.
  - Expected: PTR read at 0x2000, one TURN cycle with strobes low, then FINAL read at 0x3000.
  - done with rdata=0x1234.
- Double-indirect STI with MAX_INDIR=2, req_indir=2, chain 0x4000→0x5000→0x6000, wdata=0xA5A5.
  - Expected: two reads, then a write at 0x6000 with byte_enable=2'b11.
- STB, req_addr=0x7001, wdata=0x00C3.
  - Expected: d_mem_wdata=0xC3C3, byte_enable=2'b10.
- LDB at 0x7000 with rdata=0x80FF.
  - Expected: rdata=0x00FF.
- Flush asserted in cycle 1 of an LDI.
  - Expected: the pointer read completes on its resp, no FINAL access is issued, done never pulses, state returns to IDLE.
- Reset applied in FINAL.
  - Expected: strobes low and stall=0 on the next cycle.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared types for the MEM-stage data-memory sequencer.
//   lc3b_mseq_state : sequencer FSM states
//   lanes_of()      : byte lanes in a data word of the given width
//   lane_bits()     : address bits that select a byte lane within a word
package lc3b_types;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PTR   = 2'd1,
        TURN  = 2'd2,
        FINAL = 2'd3
    } lc3b_mseq_state;

    function automatic int lanes_of(input int width);
        return width / 8;
    endfunction

    function automatic int lane_bits(input int width);
        return $clog2(width / 8);
    endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Byte-lane handling for the final data access.
//   sel       : byte-lane index taken from the final access address
//   byte_mode : 1 = byte-sized access (LDB/STB), 0 = full word
//   rdata     : raw cache read data
//   wdata     : latched store data
//   ld_data   : load result (word, or zero-extended selected lane)
//   st_data   : store data (word, or low byte replicated to every lane)
//   be        : write byte enables (all ones, or one-hot on the lane)
import lc3b_types::*;

module byte_lane_unit #(
    parameter int WIDTH = 16,
    localparam int LANES = lanes_of(WIDTH),
    localparam int LB    = lane_bits(WIDTH)
) (
    input  logic [LB-1:0]    sel,
    input  logic             byte_mode,
    input  logic [WIDTH-1:0] rdata,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] ld_data,
    output logic [WIDTH-1:0] st_data,
    output logic [LANES-1:0] be
);

    logic [7:0] lane;

    always_comb begin
        lane    = 8'(rdata >> {sel, 3'b000});
        ld_data = rdata;
        st_data = wdata;
        be      = '1;
        if (byte_mode) begin
            ld_data = WIDTH'(lane);
            st_data = {LANES{wdata[7:0]}};
            be      = {{(LANES-1){1'b0}}, 1'b1} << sel;
        end
    end

endmodule

// File: rtl/indirect_mem_seq.sv
// MEM-stage data-memory access sequencer with up to MAX_INDIR levels of
// pointer indirection ahead of the final load/store.
//   clk, rst_n            : clock, synchronous active-low reset
//   req_*                 : memory op held in EX/MEM (sampled only in IDLE)
//   flush                 : squash; any in-flight cache strobe still completes
//   d_mem_*               : data-cache port (strobes held until d_mem_resp)
//   stall                 : freezes the upstream pipe registers
//   done / rdata          : one-cycle retire pulse with the load result
import lc3b_types::*;

module indirect_mem_seq #(
    parameter int WIDTH     = 16,
    parameter int MAX_INDIR = 2,
    localparam int LANES    = lanes_of(WIDTH),
    localparam int IW       = (MAX_INDIR > 0) ? $clog2(MAX_INDIR + 1) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    input  logic             req_write,
    input  logic             req_byte,
    input  logic [IW-1:0]    req_indir,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    input  logic             flush,
    input  logic             d_mem_resp,
    input  logic [WIDTH-1:0] d_mem_rdata,
    output logic [WIDTH-1:0] d_mem_address,
    output logic             d_mem_read,
    output logic             d_mem_write,
    output logic [WIDTH-1:0] d_mem_wdata,
    output logic [LANES-1:0] d_mem_byte_enable,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] rdata
);

    localparam int LB = lane_bits(WIDTH);

    lc3b_mseq_state state, state_nx;

    // ptr is loaded with req_addr on accept, so for a direct access it already
    // holds the final address; each pointer fetch overwrites it verbatim.
    logic [IW-1:0]    cnt;
    logic [WIDTH-1:0] ptr;
    logic [WIDTH-1:0] wdata_q;
    logic             byte_q;
    logic             write_q;
    logic             abort_q;

    logic [IW-1:0]    indir_sat;
    logic             accept;
    logic             abort_eff;
    logic [WIDTH-1:0] ld_data;
    logic [WIDTH-1:0] st_fill;
    logic [LANES-1:0] st_be;

    assign indir_sat = (req_indir > IW'(MAX_INDIR)) ? IW'(MAX_INDIR) : req_indir;
    assign accept    = (state == IDLE) && req_valid && !flush;
    // A flush arriving in the same cycle as a resp counts as an abort too.
    assign abort_eff = abort_q || flush;

    byte_lane_unit #(.WIDTH(WIDTH)) u_lane (
        .sel       (ptr[LB-1:0]),
        .byte_mode (byte_q),
        .rdata     (d_mem_rdata),
        .wdata     (wdata_q),
        .ld_data   (ld_data),
        .st_data   (st_fill),
        .be        (st_be)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            ptr     <= '0;
            wdata_q <= '0;
            byte_q  <= 1'b0;
            write_q <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                ptr     <= req_addr;
                wdata_q <= req_wdata;
                byte_q  <= req_byte;
                write_q <= req_write;
                cnt     <= indir_sat;
            end else if (state == PTR && d_mem_resp) begin
                ptr <= d_mem_rdata;
                cnt <= cnt - IW'(1);
            end
            if (state_nx == IDLE)
                abort_q <= 1'b0;
            else if (state != IDLE && flush)
                abort_q <= 1'b1;
        end
    end

    always_comb begin
        state_nx          = state;
        d_mem_read        = 1'b0;
        d_mem_write       = 1'b0;
        d_mem_address     = '0;
        d_mem_wdata       = '0;
        d_mem_byte_enable = '0;
        stall             = 1'b0;
        done              = 1'b0;
        rdata             = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    stall    = 1'b1;
                    state_nx = (indir_sat != '0) ? PTR : FINAL;
                end
            end
            PTR: begin
                d_mem_read    = 1'b1;
                d_mem_address = {ptr[WIDTH-1:LB], {LB{1'b0}}};
                stall         = 1'b1;
                if (d_mem_resp) begin
                    if (abort_eff) begin
                        stall    = 1'b0;
                        state_nx = IDLE;
                    end else begin
                        state_nx = TURN;
                    end
                end
            end
            TURN: begin
                if (abort_eff) begin
                    state_nx = IDLE;
                end else begin
                    stall    = 1'b1;
                    state_nx = (cnt != '0) ? PTR : FINAL;
                end
            end
            FINAL: begin
                d_mem_address = ptr;
                d_mem_read    = !write_q;
                d_mem_write   = write_q;
                if (write_q) begin
                    d_mem_wdata       = st_fill;
                    d_mem_byte_enable = st_be;
                end
                stall = !d_mem_resp;
                if (d_mem_resp) begin
                    done     = !abort_eff;
                    rdata    = abort_eff ? '0 : ld_data;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_indirect_mem_seq.sv
// Scoreboard bench for indirect_mem_seq (WIDTH=16, MAX_INDIR=2).
// A memory responder answers strobes after resp_wait cycles; expected read
// addresses, writes and retire results are queued when a request is driven
// and popped as the DUT produces them.
module tb_indirect_mem_seq;

    localparam int W  = 16;
    localparam int MI = 2;
    localparam int L  = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0, req_write = 1'b0, req_byte = 1'b0;
    logic [1:0]   req_indir = '0;
    logic [W-1:0] req_addr = '0, req_wdata = '0;
    logic         flush = 1'b0;
    logic         d_mem_resp = 1'b0;
    logic [W-1:0] d_mem_rdata = '0;
    logic [W-1:0] d_mem_address, d_mem_wdata, rdata;
    logic         d_mem_read, d_mem_write, stall, done;
    logic [L-1:0] d_mem_byte_enable;

    indirect_mem_seq #(.WIDTH(W), .MAX_INDIR(MI)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_write(req_write), .req_byte(req_byte),
        .req_indir(req_indir), .req_addr(req_addr), .req_wdata(req_wdata),
        .flush(flush), .d_mem_resp(d_mem_resp), .d_mem_rdata(d_mem_rdata),
        .d_mem_address(d_mem_address), .d_mem_read(d_mem_read),
        .d_mem_write(d_mem_write), .d_mem_wdata(d_mem_wdata),
        .d_mem_byte_enable(d_mem_byte_enable),
        .stall(stall), .done(done), .rdata(rdata)
    );

    always #5 clk = ~clk;

    typedef struct { logic [W-1:0] addr; logic [W-1:0] data; logic [L-1:0] be; } wr_t;
    typedef struct { bit chk; logic [W-1:0] val; } dn_t;

    logic [W-1:0] exp_rd[$];
    wr_t          exp_wr[$];
    dn_t          exp_dn[$];
    logic [W-1:0] mem [logic [W-1:0]];

    int vecs = 0, miss = 0;
    int resp_wait = 0, wcnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            miss++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rd_mem(input logic [W-1:0] a);
        logic [W-1:0] k;
        k = a & ~16'h0001;
        return mem.exists(k) ? mem[k] : '0;
    endfunction

    // memory responder: acts 1 time unit after each rising edge
    logic [W-1:0] ra;
    wr_t          wx;
    dn_t          dx;
    always @(posedge clk) begin
        #1;
        d_mem_resp = 1'b0;
        if (d_mem_read || d_mem_write) begin
            if (wcnt >= resp_wait) begin
                wcnt = 0;
                d_mem_resp = 1'b1;
                if (d_mem_read) begin
                    d_mem_rdata = rd_mem(d_mem_address);
                    if (exp_rd.size() == 0) chk("unexp_rd", 32'd1, 32'd0);
                    else begin
                        ra = exp_rd.pop_front();
                        chk("rd_addr", 32'(d_mem_address), 32'(ra));
                    end
                end else begin
                    if (exp_wr.size() == 0) chk("unexp_wr", 32'd1, 32'd0);
                    else begin
                        wx = exp_wr.pop_front();
                        chk("wr_addr", 32'(d_mem_address), 32'(wx.addr));
                        chk("wr_data", 32'(d_mem_wdata), 32'(wx.data));
                        chk("wr_be", 32'(d_mem_byte_enable), 32'(wx.be));
                    end
                end
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
    end

    // retire monitor
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_dn.size() == 0) chk("unexp_done", 32'd1, 32'd0);
            else begin
                dx = exp_dn.pop_front();
                if (dx.chk) chk("rdata", 32'(rdata), 32'(dx.val));
            end
        end
    end

    function automatic dn_t mk_dn(input bit c, input logic [W-1:0] v);
        dn_t d;
        d.chk = c;
        d.val = v;
        return d;
    endfunction

    function automatic wr_t mk_wr(input logic [W-1:0] a, input logic [W-1:0] d, input logic [L-1:0] b);
        wr_t x;
        x.addr = a;
        x.data = d;
        x.be   = b;
        return x;
    endfunction

    // Drive one request (called at posedge+1) and wait for its retire pulse.
    task automatic run_req(input bit wr, input bit bt, input logic [1:0] ind,
                           input logic [W-1:0] addr, input logic [W-1:0] wd,
                           input int w, input int exp_lat);
        int  cyc;
        bit  got;
        resp_wait = w;
        req_valid = 1'b1; req_write = wr; req_byte = bt;
        req_indir = ind;  req_addr  = addr; req_wdata = wd;
        @(negedge clk);
        chk("acc_stall", 32'(stall), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        cyc = 1;
        got = 1'b0;
        while (cyc < 60 && !got) begin
            @(negedge clk);
            if (done) got = 1'b1;
            else begin
                chk("busy_stall", 32'(stall), 32'd1);
                cyc++;
            end
        end
        chk("latency", got ? 32'(cyc) : 32'hFFFF_FFFF, 32'(exp_lat));
        if (got) chk("done_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        mem[16'h1000] = 16'hBEEF;
        mem[16'h2000] = 16'h3000;
        mem[16'h3000] = 16'h1234;
        mem[16'h4000] = 16'h5000;
        mem[16'h5000] = 16'h6000;
        mem[16'h6000] = 16'h7777;
        mem[16'h7000] = 16'h80FF;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_read",  32'(d_mem_read), 32'd0);
        chk("rst_write", 32'(d_mem_write), 32'd0);
        chk("rst_addr",  32'(d_mem_address), 32'd0);
        chk("rst_wdata", 32'(d_mem_wdata), 32'd0);
        chk("rst_be",    32'(d_mem_byte_enable), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_done",  32'(done), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // direct LDR, 1 wait cycle
        exp_rd.push_back(16'h1000); exp_dn.push_back(mk_dn(1, 16'hBEEF));
        run_req(0, 0, 2'd0, 16'h1000, 16'h0, 1, 2);

        // LDI from unaligned pointer address
        exp_rd.push_back(16'h2000); exp_rd.push_back(16'h3000);
        exp_dn.push_back(mk_dn(1, 16'h1234));
        run_req(0, 0, 2'd1, 16'h2001, 16'h0, 0, 3);

        // double-indirect STI, 1 wait per access
        exp_rd.push_back(16'h4000); exp_rd.push_back(16'h5000);
        exp_wr.push_back(mk_wr(16'h6000, 16'hA5A5, 2'b11));
        exp_dn.push_back(mk_dn(0, 16'h0));
        run_req(1, 0, 2'd2, 16'h4000, 16'hA5A5, 1, 8);

        // STB to odd lane
        exp_wr.push_back(mk_wr(16'h7001, 16'hC3C3, 2'b10));
        exp_dn.push_back(mk_dn(0, 16'h0));
        run_req(1, 1, 2'd0, 16'h7001, 16'h00C3, 0, 1);

        // LDB low lane, then high lane with 2 wait cycles
        exp_rd.push_back(16'h7000); exp_dn.push_back(mk_dn(1, 16'h00FF));
        run_req(0, 1, 2'd0, 16'h7000, 16'h0, 0, 1);
        exp_rd.push_back(16'h7001); exp_dn.push_back(mk_dn(1, 16'h0080));
        run_req(0, 1, 2'd0, 16'h7001, 16'h0, 2, 3);

        // direct word STR
        exp_wr.push_back(mk_wr(16'h1234, 16'h5A5A, 2'b11));
        exp_dn.push_back(mk_dn(0, 16'h0));
        run_req(1, 0, 2'd0, 16'h1234, 16'h5A5A, 0, 1);

        // req_indir=3 saturates to 2 levels
        exp_rd.push_back(16'h4000); exp_rd.push_back(16'h5000); exp_rd.push_back(16'h6000);
        exp_dn.push_back(mk_dn(1, 16'h7777));
        run_req(0, 0, 2'd3, 16'h4000, 16'h0, 0, 5);

        // flush in IDLE: request ignored
        req_valid = 1'b1; flush = 1'b1; req_write = 1'b0; req_indir = 2'd0; req_addr = 16'h1000;
        @(negedge clk);
        chk("idle_flush_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("idle_flush_read", 32'(d_mem_read), 32'd0);
        @(posedge clk); #1;

        // flush in cycle 1 of an LDI: pointer read completes, nothing after
        resp_wait = 1;
        exp_rd.push_back(16'h2000);
        req_valid = 1'b1; req_byte = 1'b0; req_indir = 2'd1; req_addr = 16'h2001;
        @(posedge clk); #1;
        req_valid = 1'b0; flush = 1'b1;
        @(negedge clk);
        chk("fl_c1_read", 32'(d_mem_read), 32'd1);
        chk("fl_c1_stall", 32'(stall), 32'd1);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("fl_c2_resp", 32'(d_mem_resp), 32'd1);
        chk("fl_c2_stall", 32'(stall), 32'd0);
        chk("fl_c2_done", 32'(done), 32'd0);
        @(negedge clk);
        chk("fl_c3_strobes", 32'({d_mem_read, d_mem_write}), 32'd0);
        chk("fl_c3_stall", 32'(stall), 32'd0);
        repeat (4) @(negedge clk);
        chk("fl_idle_read", 32'(d_mem_read), 32'd0);
        @(posedge clk); #1;

        // reset while in FINAL
        resp_wait = 3;
        req_valid = 1'b1; req_indir = 2'd0; req_addr = 16'h1000;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rf_final_read", 32'(d_mem_read), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rf_strobes", 32'({d_mem_read, d_mem_write}), 32'd0);
        chk("rf_stall", 32'(stall), 32'd0);
        chk("rf_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // back-to-back after reset recovery
        exp_rd.push_back(16'h1000); exp_dn.push_back(mk_dn(1, 16'hBEEF));
        run_req(0, 0, 2'd0, 16'h1000, 16'h0, 0, 1);
        exp_rd.push_back(16'h7000); exp_dn.push_back(mk_dn(1, 16'h80FF));
        run_req(0, 0, 2'd0, 16'h7000, 16'h0, 0, 1);

        repeat (3) @(posedge clk);
        chk("queues_empty", 32'(exp_rd.size() + exp_wr.size() + exp_dn.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
